// File: rtl/dr_ald_pkg.sv
// Shared definitions for the dynamic-range approximate log divider.
package dr_ald_pkg;

  // Widest operand the divider is built for; the exponent type is sized for it.
  localparam int PKG_DW = 16;
  localparam int K_W    = $clog2(PKG_DW);

  // Signed exponent difference, with headroom for the borrow decrement.
  typedef logic signed [K_W+1:0] exp_t;

  // Largest positive quotient for the widest operand.
  localparam logic [PKG_DW-1:0] QMAX = {1'b0, {(PKG_DW-1){1'b1}}};

  // Leading-one position; an all-zero input reports 0.
  function automatic logic [K_W-1:0] lod(input logic [PKG_DW-1:0] v);
    lod = '0;
    for (int i = 0; i < PKG_DW; i++) begin
      if (v[i]) lod = K_W'(i);
    end
  endfunction

endpackage

// File: rtl/ald_antilog_shift.sv
// Antilog: scales the log-domain mantissa by 2^(e - M_WIDTH) and saturates
// the magnitude to the largest positive quotient.
module ald_antilog_shift
  import dr_ald_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int M_WIDTH = 6
) (
  input  logic [M_WIDTH:0]  mant,
  input  exp_t              e,
  output logic [DWIDTH-1:0] mag
);

  // Wide enough that the largest left shift never drops set bits.
  localparam int WW = DWIDTH + M_WIDTH + 2;
  localparam logic [PKG_DW-1:0] SAT_W = QMAX >> (PKG_DW - DWIDTH);
  localparam logic [DWIDTH-1:0] SAT   = SAT_W[DWIDTH-1:0];

  function automatic logic [DWIDTH-1:0] sat_mag(input logic [WW-1:0] v);
    if (v > WW'(SAT)) sat_mag = SAT;
    else              sat_mag = v[DWIDTH-1:0];
  endfunction

  logic [WW-1:0] wide;
  int            e_i;

  // Shift left for large exponents, truncating right shift otherwise.
  always_comb begin
    e_i  = int'(e);
    wide = '0;
    if (e_i >= M_WIDTH) begin
      wide = WW'(mant) << (e_i - M_WIDTH);
    end else if ((M_WIDTH - e_i) < (M_WIDTH + 2)) begin
      wide = WW'(mant) >> (M_WIDTH - e_i);
    end
    mag = sat_mag(wide);
  end

endmodule

// File: rtl/dr_ald_pipe.sv
// Pipelined signed approximate divider, q ~ a / b, computed as a subtraction
// in the log domain with truncated mantissas whose LSB is forced to 1.
// Operands are registered on acceptance, then pass through sign/LOD,
// mantissa subtraction and antilog stages into the output register.
module dr_ald_pipe
  import dr_ald_pkg::*;
#(
  parameter int DWIDTH  = 16,
  parameter int M_WIDTH = 6
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic signed [DWIDTH-1:0] i_a,
  input  logic signed [DWIDTH-1:0] i_b,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic signed [DWIDTH-1:0] o_q,
  output logic                     o_dz
);

  localparam logic [PKG_DW-1:0] SAT_W = QMAX >> (PKG_DW - DWIDTH);
  localparam logic [DWIDTH-1:0] SAT   = SAT_W[DWIDTH-1:0];

  // Exact magnitude; the most negative value maps onto 2^(DWIDTH-1).
  function automatic logic [DWIDTH-1:0] abs_mag(input logic signed [DWIDTH-1:0] v);
    logic [DWIDTH-1:0] u;
    u = v;
    abs_mag = u[DWIDTH-1] ? (~u + DWIDTH'(1)) : u;
  endfunction

  // Truncated fraction below the leading one, with the LSB forced to 1.
  function automatic logic [M_WIDTH-1:0] trunc_frac(input logic [DWIDTH-1:0] m,
                                                    input logic [K_W-1:0]    k);
    logic [DWIDTH-1:0] n;
    n = m << (DWIDTH - 1 - int'(k));
    trunc_frac = {n[DWIDTH-2 -: M_WIDTH-1], 1'b1};
  endfunction

  function automatic logic signed [DWIDTH-1:0] apply_sign(input logic neg,
                                                          input logic [DWIDTH-1:0] m);
    apply_sign = neg ? $signed(DWIDTH'(0) - m) : $signed(m);
  endfunction

  logic vld_p0, vld_p1, vld_p2, vld_p3;
  logic ld_p0, ld_p1, ld_p2, ld_p3;

  // A stage loads when empty or when its occupant moves on this edge.
  assign ld_p3   = !vld_p3 || i_ready;
  assign ld_p2   = !vld_p2 || ld_p3;
  assign ld_p1   = !vld_p1 || ld_p2;
  assign ld_p0   = !vld_p0 || ld_p1;
  assign o_ready = ld_p0;
  assign o_valid = vld_p3;

  // Stage valid bits; reset discards everything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
      vld_p3 <= 1'b0;
    end else begin
      if (ld_p0) vld_p0 <= i_valid;
      if (ld_p1) vld_p1 <= vld_p0;
      if (ld_p2) vld_p2 <= vld_p1;
      if (ld_p3) vld_p3 <= vld_p2;
    end
  end

  // ---- p0: accepted operands ----
  logic signed [DWIDTH-1:0] a_p0, b_p0;

  // Capture operands on an input transfer.
  always_ff @(posedge i_clk) begin
    if (ld_p0 && i_valid) begin
      a_p0 <= i_a;
      b_p0 <= i_b;
    end
  end

  // ---- p1: sign, magnitudes, leading-one positions, zero flags ----
  logic [DWIDTH-1:0] mag_a_s1, mag_b_s1, mag_a_p1, mag_b_p1;
  logic [K_W-1:0]    ka_p1, kb_p1;
  logic              sign_p1, aneg_p1, za_p1, zb_p1;

  assign mag_a_s1 = abs_mag(a_p0);
  assign mag_b_s1 = abs_mag(b_p0);

  // Register sign/LOD results.
  always_ff @(posedge i_clk) begin
    if (ld_p1 && vld_p0) begin
      sign_p1  <= a_p0[DWIDTH-1] ^ b_p0[DWIDTH-1];
      aneg_p1  <= a_p0[DWIDTH-1];
      mag_a_p1 <= mag_a_s1;
      mag_b_p1 <= mag_b_s1;
      ka_p1    <= lod(PKG_DW'(mag_a_s1));
      kb_p1    <= lod(PKG_DW'(mag_b_s1));
      za_p1    <= (a_p0 == '0);
      zb_p1    <= (b_p0 == '0);
    end
  end

  // ---- p2: log-domain subtraction ----
  logic [M_WIDTH-1:0] xa_s2, xb_s2, diff_s2;
  logic               borrow_s2;
  logic [M_WIDTH:0]   mant_s2, mant_p2;
  exp_t               e_s2, e_p2;
  logic               sign_p2, aneg_p2, za_p2, zb_p2;

  // Both branches reduce to {1, xa - xb mod 2^M_WIDTH}: on a borrow,
  // 2^(M_WIDTH+1) + xa - xb still lies between 2^M_WIDTH and 2^(M_WIDTH+1).
  always_comb begin
    xa_s2     = trunc_frac(mag_a_p1, ka_p1);
    xb_s2     = trunc_frac(mag_b_p1, kb_p1);
    borrow_s2 = (xa_s2 < xb_s2);
    diff_s2   = xa_s2 - xb_s2;
    mant_s2   = {1'b1, diff_s2};
    e_s2      = $signed({2'b00, ka_p1}) - $signed({2'b00, kb_p1})
              - (borrow_s2 ? exp_t'(1) : exp_t'(0));
  end

  // Register mantissa, exponent and flags.
  always_ff @(posedge i_clk) begin
    if (ld_p2 && vld_p1) begin
      mant_p2 <= mant_s2;
      e_p2    <= e_s2;
      sign_p2 <= sign_p1;
      aneg_p2 <= aneg_p1;
      za_p2   <= za_p1;
      zb_p2   <= zb_p1;
    end
  end

  // ---- p3: antilog, sign and zero handling, output register ----
  logic [DWIDTH-1:0]        mag_s3;
  logic signed [DWIDTH-1:0] q_s3, q_p3;
  logic                     dz_s3, dz_p3;

  ald_antilog_shift #(
    .DWIDTH (DWIDTH),
    .M_WIDTH(M_WIDTH)
  ) u_antilog (
    .mant(mant_p2),
    .e   (e_p2),
    .mag (mag_s3)
  );

  // Divide-by-zero saturates toward the dividend's sign; 0/0 gives 0.
  always_comb begin
    q_s3  = apply_sign(sign_p2, mag_s3);
    dz_s3 = 1'b0;
    if (zb_p2) begin
      dz_s3 = 1'b1;
      q_s3  = za_p2 ? '0 : apply_sign(aneg_p2, SAT);
    end else if (za_p2) begin
      q_s3 = '0;
    end
  end

  // Output register holds its value while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      q_p3  <= '0;
      dz_p3 <= 1'b0;
    end else if (ld_p3 && vld_p2) begin
      q_p3  <= q_s3;
      dz_p3 <= dz_s3;
    end
  end

  assign o_q  = q_p3;
  assign o_dz = dz_p3;

endmodule

// File: tb/tb_dr_ald_pipe.sv
// Directed bench for dr_ald_pipe (DWIDTH=16, M_WIDTH=6).
module tb_dr_ald_pipe;

  logic               i_clk;
  logic               i_rst_n;
  logic               i_valid;
  logic               o_ready;
  logic signed [15:0] i_a;
  logic signed [15:0] i_b;
  logic               o_valid;
  logic               i_ready;
  logic signed [15:0] o_q;
  logic               o_dz;

  int n_chk = 0;
  int n_bad = 0;

  dr_ald_pipe #(
    .DWIDTH (16),
    .M_WIDTH(6)
  ) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_a    (i_a),
    .i_b    (i_b),
    .o_valid(o_valid),
    .i_ready(i_ready),
    .o_q    (o_q),
    .o_dz   (o_dz)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One isolated division on an empty pipe with i_ready high.
  task automatic run_one(input string tag, input int a, input int b,
                         input int exp_q, input int exp_dz);
    int cnt;
    i_ready = 1'b1;
    i_valid = 1'b1;
    i_a     = 16'(a);
    i_b     = 16'(b);
    #1;
    chk({tag, "_rdy"}, int'(o_ready), 1);
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    cnt = 0;
    while (!o_valid && cnt < 8) begin
      @(posedge i_clk); #1;
      cnt++;
    end
    chk({tag, "_lat"}, cnt, 3);
    chk({tag, "_q"}, int'(o_q), exp_q);
    chk({tag, "_dz"}, int'(o_dz), exp_dz);
    @(posedge i_clk); #1;
  endtask

  int va[4] = '{100, 7, 5, -100};
  int vb[4] = '{10, 7, 100, 10};
  int vq[4] = '{10, 1, 0, -10};

  initial begin
    int nin, nout, seen;
    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_a     = '0;
    i_b     = '0;
    #1;
    chk("rst_vld", int'(o_valid), 0);
    chk("rst_q", int'(o_q), 0);
    chk("rst_dz", int'(o_dz), 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    run_one("d100_10", 100, 10, 10, 0);
    run_one("dm100_10", -100, 10, -10, 0);
    run_one("d7_m7", 7, -7, -1, 0);
    run_one("d5_100", 5, 100, 0, 0);
    run_one("sat", -32768, -1, 32767, 0);
    run_one("dz_pos", 1234, 0, 32767, 1);
    run_one("dz_neg", -5, 0, -32767, 1);
    run_one("dz_zero", 0, 0, 0, 1);
    run_one("zero_a", 0, 5, 0, 0);

    // Back-to-back stream with a consumer stall on cycles 4..7.
    nin  = 0;
    nout = 0;
    for (int c = 0; c < 24; c++) begin
      i_ready = (c >= 4 && c <= 7) ? 1'b0 : 1'b1;
      i_valid = (nin < 4);
      if (nin < 4) begin
        i_a = 16'(va[nin]);
        i_b = 16'(vb[nin]);
      end
      #1;
      if (c == 4) chk("strm_full_rdy", int'(o_ready), 0);
      if (o_valid && !i_ready && nout < 4) chk("strm_hold_q", int'(o_q), vq[nout]);
      if (o_valid && i_ready) begin
        if (nout < 4) chk("strm_q", int'(o_q), vq[nout]);
        nout++;
      end
      if (i_valid && o_ready) nin++;
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    chk("strm_in", nin, 4);
    chk("strm_out", nout, 4);

    // Asynchronous reset with two operands in flight.
    i_ready = 1'b0;
    i_valid = 1'b1;
    i_a = 16'sd100;
    i_b = 16'sd10;
    @(posedge i_clk); #1;
    i_a = 16'sd7;
    i_b = 16'sd7;
    @(posedge i_clk); #1;
    i_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    chk("pre_rst_vld", int'(o_valid), 1);
    chk("pre_rst_q", int'(o_q), 10);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("arst_vld", int'(o_valid), 0);
    chk("arst_q", int'(o_q), 0);
    chk("arst_dz", int'(o_dz), 0);
    @(posedge i_clk); #3;
    i_rst_n = 1'b1;
    i_ready = 1'b1;
    seen = 0;
    repeat (8) begin
      @(posedge i_clk); #1;
      if (o_valid) seen++;
    end
    chk("post_rst_stale", seen, 0);
    run_one("post_rst", 100, 10, 10, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
